// File: rtl/sqrt_seq_ctrl.sv
// Sequential controller for the iterative (Heron) square-root datapath.
// Optional feature: define SQRT_ZERO_BYPASS_EN to short-circuit n == 0 from INIT straight to OUT.
module sqrt_seq_ctrl #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned R_N      = 1,
    parameter int unsigned R_X      = 2,
    parameter int unsigned R_ROOT   = 3,
    parameter int unsigned R_TEMP   = 4,
    parameter int unsigned R_TWO    = 5,
    parameter int unsigned R_EPS    = 6,
    parameter int unsigned R_OUT    = 7,
    parameter int unsigned MAX_ITER = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              neg_flag,
    input  logic              zero_flag,
    output logic              IE,
    output logic              WE,
    output logic              OE,
    output logic [ADDR_W-1:0] ADDR_WR,
    output logic [ADDR_W-1:0] ADDR_RDA,
    output logic [ADDR_W-1:0] ADDR_RDB,
    output logic [1:0]        ALU_Op,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [3:0]        state_o
);

    localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

    localparam logic [ADDR_W-1:0] A_N    = ADDR_W'(R_N);
    localparam logic [ADDR_W-1:0] A_X    = ADDR_W'(R_X);
    localparam logic [ADDR_W-1:0] A_ROOT = ADDR_W'(R_ROOT);
    localparam logic [ADDR_W-1:0] A_TEMP = ADDR_W'(R_TEMP);
    localparam logic [ADDR_W-1:0] A_TWO  = ADDR_W'(R_TWO);
    localparam logic [ADDR_W-1:0] A_EPS  = ADDR_W'(R_EPS);
    localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(R_OUT);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_ABS = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_INIT = 4'd2,
        S_DIV  = 4'd3,
        S_ADD  = 4'd4,
        S_HALF = 4'd5,
        S_DIFF = 4'd6,
        S_ABS  = 4'd7,
        S_CMP  = 4'd8,
        S_UPD  = 4'd9,
        S_OUT  = 4'd10
    } state_e;

    state_e              state_q, state_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic                timeout_q, timeout_d;
    logic                bypass_q, bypass_d;

`ifndef SQRT_ZERO_BYPASS_EN
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            iter_q    <= '0;
            timeout_q <= 1'b0;
            bypass_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            timeout_q <= timeout_d;
            bypass_q  <= bypass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        timeout_d = timeout_q;
        bypass_d  = bypass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                    bypass_d  = 1'b0;
                end
            end
            S_LOAD: state_d = S_INIT;
            S_INIT: begin
`ifdef SQRT_ZERO_BYPASS_EN
                if (zero_flag) begin
                    state_d  = S_OUT;
                    bypass_d = 1'b1;
                end else begin
                    state_d = S_DIV;
                end
`else
                state_d = S_DIV;
`endif
            end
            S_DIV:  state_d = S_ADD;
            S_ADD:  state_d = S_HALF;
            S_HALF: state_d = S_DIFF;
            S_DIFF: state_d = S_ABS;
            S_ABS:  state_d = S_CMP;
            S_CMP: begin
                // iter_q counts iterations finished before this compare
                if (neg_flag) begin
                    state_d = S_OUT;
                end else if (iter_q == ITER_LAST) begin
                    state_d   = S_OUT;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_UPD;
                    iter_d  = iter_q + ITER_W'(1);
                end
            end
            S_UPD:  state_d = S_DIV;
            S_OUT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IE       = 1'b0;
        WE       = 1'b0;
        OE       = 1'b0;
        ADDR_WR  = '0;
        ADDR_RDA = '0;
        ADDR_RDB = '0;
        ALU_Op   = OP_ADD;
        done     = 1'b0;
        case (state_q)
            S_LOAD: begin IE = 1'b1; WE = 1'b1; ADDR_WR = A_N; end
            S_INIT: begin WE = 1'b1; ADDR_WR = A_X; ADDR_RDA = A_N; end
            S_DIV: begin
                WE = 1'b1; ADDR_WR = A_ROOT; ADDR_RDA = A_N; ADDR_RDB = A_X; ALU_Op = OP_DIV;
            end
            S_ADD: begin
                WE = 1'b1; ADDR_WR = A_ROOT; ADDR_RDA = A_ROOT; ADDR_RDB = A_X;
            end
            S_HALF: begin
                WE = 1'b1; ADDR_WR = A_ROOT; ADDR_RDA = A_ROOT; ADDR_RDB = A_TWO; ALU_Op = OP_DIV;
            end
            S_DIFF: begin
                WE = 1'b1; ADDR_WR = A_TEMP; ADDR_RDA = A_ROOT; ADDR_RDB = A_X; ALU_Op = OP_SUB;
            end
            S_ABS: begin
                WE = 1'b1; ADDR_WR = A_TEMP; ADDR_RDA = A_TEMP; ALU_Op = OP_ABS;
            end
            S_CMP: begin
                WE = 1'b1; ADDR_WR = A_TEMP; ADDR_RDA = A_TEMP; ADDR_RDB = A_EPS; ALU_Op = OP_SUB;
            end
            S_UPD:  begin WE = 1'b1; ADDR_WR = A_X; ADDR_RDA = A_ROOT; end
            S_OUT: begin
                OE       = 1'b1;
                ADDR_WR  = A_OUT;
                ADDR_RDA = bypass_q ? A_N : A_ROOT;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign timeout = timeout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Self-checking bench for sqrt_seq_ctrl: cycle-indexed reference schedule per scenario,
// directed scenario table plus randomized scenarios and flag noise.
module tb_sqrt_seq_ctrl;

    localparam int unsigned AW   = 3;
    localparam int unsigned MAXI = 8;
    localparam int unsigned RN   = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, neg_flag, zero_flag;
    logic IE, WE, OE, busy, done, timeout;
    logic [AW-1:0] ADDR_WR, ADDR_RDA, ADDR_RDB;
    logic [1:0] ALU_Op;
    logic [3:0] state_o;

    sqrt_seq_ctrl #(
        .ADDR_W(AW), .R_N(RN), .R_X(2), .R_ROOT(3), .R_TEMP(4),
        .R_TWO(5), .R_EPS(6), .R_OUT(7), .MAX_ITER(MAXI)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .neg_flag(neg_flag), .zero_flag(zero_flag),
        .IE(IE), .WE(WE), .OE(OE), .ADDR_WR(ADDR_WR), .ADDR_RDA(ADDR_RDA),
        .ADDR_RDB(ADDR_RDB), .ALU_Op(ALU_Op), .busy(busy), .done(done),
        .timeout(timeout), .state_o(state_o)
    );

    typedef struct {
        bit ie, we, oe;
        int wr, rda, rdb, alu;
    } ctl_t;

    typedef struct {
        int k;       // CMP index where neg_flag is raised; outside 1..MAXI means never
        bit zero;    // zero_flag value in INIT
        bit mid;     // pulse start during ADD
        int rst_at;  // assert rst in this cycle (0 = never)
        int idle;    // idle cycles checked after the run
    } scen_t;

    ctl_t  ctl[11];
    scen_t tab[7];
    int    n_chk = 0;
    int    n_fail = 0;
    bit    prev_to = 1'b0;

    logic [20:0] act;
    assign act = {IE, WE, OE, ADDR_WR, ADDR_RDA, ADDR_RDB, ALU_Op, busy, done, timeout, state_o};

    function automatic logic [20:0] exp_vec(int s, bit byp, bit to);
        ctl_t t;
        int   rda;
        t = ctl[s];
        rda = (byp && s == 10) ? int'(RN) : t.rda;
        return {t.ie, t.we, t.oe, 3'(t.wr), 3'(rda), 3'(t.rdb), 2'(t.alu),
                (s != 0), (s == 10), to, 4'(s)};
    endfunction

    // State expected in cycle c of a run whose OUT lands in cycle d.
    function automatic int exp_state(int c, int d);
        int o;
        if (c == d) return 10;
        if (c <= 8) return c;
        o = (c - 9) % 7;
        return (o == 0) ? 9 : o + 2;
    endfunction

    task automatic check(input string nm, input logic [20:0] e);
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    endtask

    task automatic idle_cycles(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s idle%0d", nm, i), exp_vec(0, 1'b0, prev_to));
        end
    endtask

    // Called at a negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
    task automatic run(input string nm, input int k, input bit zero, input bit mid, input int rst_at);
        int d, last;
        bit to, byp, is_cmp;
        byp = 1'b0;
`ifdef SQRT_ZERO_BYPASS_EN
        byp = zero;
`endif
        if (byp) begin
            d = 3; to = 1'b0;
        end else if (k >= 1 && k <= int'(MAXI)) begin
            d = 7 * k + 2; to = 1'b0;
        end else begin
            d = 7 * int'(MAXI) + 2; to = 1'b1;
        end
        last = (rst_at > 0) ? rst_at : d;
        start = 1'b1; neg_flag = 1'b0; zero_flag = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", nm, c), exp_vec(exp_state(c, d), byp, (c == d) ? to : 1'b0));
            start = mid && (c == 4);
            is_cmp = (c >= 8) && ((c - 8) % 7 == 0);
            neg_flag = is_cmp ? (c == 7 * k + 1) : 1'($urandom);
            zero_flag = (c == 2) ? zero : 1'($urandom);
            if (c == rst_at) rst = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0; neg_flag = 1'b0; zero_flag = 1'b0;
        if (rst_at > 0) to = 1'b0;
        prev_to = to;
        check($sformatf("%s end", nm), exp_vec(0, 1'b0, to));
        rst = 1'b0;
    endtask

    initial begin
        ctl[0]  = '{0,0,0, 0,0,0, 0};
        ctl[1]  = '{1,1,0, 1,0,0, 0};
        ctl[2]  = '{0,1,0, 2,1,0, 0};
        ctl[3]  = '{0,1,0, 3,1,2, 2};
        ctl[4]  = '{0,1,0, 3,3,2, 0};
        ctl[5]  = '{0,1,0, 3,3,5, 2};
        ctl[6]  = '{0,1,0, 4,3,2, 1};
        ctl[7]  = '{0,1,0, 4,4,0, 3};
        ctl[8]  = '{0,1,0, 4,4,6, 1};
        ctl[9]  = '{0,1,0, 2,3,0, 0};
        ctl[10] = '{0,0,1, 7,3,0, 0};

        tab[0] = '{1,  0, 0, 0, 0};
        tab[1] = '{3,  0, 0, 0, 0};
        tab[2] = '{99, 0, 0, 0, 4};
        tab[3] = '{2,  0, 0, 0, 0};
        tab[4] = '{1,  1, 0, 0, 1};
        tab[5] = '{2,  0, 1, 0, 0};
        tab[6] = '{1,  0, 0, 5, 6};

        rst = 1'b1; start = 1'b1; neg_flag = 1'b0; zero_flag = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("reset%0d", i), exp_vec(0, 1'b0, 1'b0));
        end
        rst = 1'b0; start = 1'b0;
        idle_cycles(1, "post_reset");

        for (int i = 0; i < 7; i++) begin
            run($sformatf("dir%0d", i), tab[i].k, tab[i].zero, tab[i].mid, tab[i].rst_at);
            if (tab[i].idle > 0) idle_cycles(tab[i].idle, $sformatf("dir%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            run($sformatf("rnd%0d", i), int'($urandom_range(1, 10)),
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 0);
        end
        idle_cycles(2, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_seq_ctrl.md
# sqrt_seq_ctrl

Sequential controller for the iterative square-root datapath: the next generation of the stateless state-to-control decoder. It owns the state register, a start/done handshake and an iteration counter with a timeout limit, and it branches on a convergence flag from the datapath. It drives the register-file/ALU datapath (IE, WE, OE, read/write addresses, ALU_Op) through Heron iterations x ← (n/x + x)/2 until |root − x| < ε.

## Interface
Parameters:
- ADDR_W, 3: register-file address width.
- R_N, 1: register index of n.
- R_X, 2: register index of x.
- R_ROOT, 3: register index of root.
- R_TEMP, 4: register index of temp.
- R_TWO, 5: register index of the constant 2.
- R_EPS, 6: register index of ε.
- R_OUT, 7: write address driven during output.
- MAX_ITER, 8: iteration limit (≥1). Counter width is a localparam, ITER_W = $clog2(MAX_ITER+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a computation; sampled in IDLE only.
- neg_flag  in  1  sign of the current ALU result; valid combinationally in CMP.
- zero_flag  in  1  current ALU result == 0; valid combinationally in INIT.
- IE, WE, OE  out  1 each  input enable, register write enable, output enable.
- ADDR_WR, ADDR_RDA, ADDR_RDB  out  ADDR_W each  register-file write and read addresses.
- ALU_Op  out  2  ALU operation: 00 add/pass, 01 sub, 10 div, 11 abs.
- busy  out  1  high when state ≠ IDLE.
- done  out  1  high for exactly one cycle, in OUT.
- timeout  out  1  registered; set on limit exit, cleared on the next accepted start.
- state_o  out  4  current state, for debug.

## Operation
States and their encoding:

| State | Code | Enables | ADDR_WR | ADDR_RDA | ADDR_RDB | ALU_Op |
|---|---|---|---|---|---|---|
| IDLE | 0 | all 0 | 0 | 0 | 0 | 00 |
| LOAD | 1 | IE, WE | R_N | 0 | 0 | 00 |
| INIT | 2 | WE | R_X | R_N | 0 | 00 |
| DIV | 3 | WE | R_ROOT | R_N | R_X | 10 |
| ADD | 4 | WE | R_ROOT | R_ROOT | R_X | 00 |
| HALF | 5 | WE | R_ROOT | R_ROOT | R_TWO | 10 |
| DIFF | 6 | WE | R_TEMP | R_ROOT | R_X | 01 |
| ABS | 7 | WE | R_TEMP | R_TEMP | 0 | 11 |
| CMP | 8 | WE | R_TEMP | R_TEMP | R_EPS | 01 |
| UPD | 9 | WE | R_X | R_ROOT | 0 | 00 |
| OUT | 10 | OE | R_OUT | R_ROOT (R_N on bypass) | 0 | 00 |

Codes 11–15 are illegal: they decode to all-zero controls and go to IDLE on the next edge.

Transitions:
- IDLE → LOAD when start=1.
- LOAD → INIT → DIV → ADD → HALF → DIFF → ABS → CMP, unconditionally.
- In CMP, with iter = iterations completed before this one:
  - neg_flag=1 → OUT (converged).
  - Otherwise, if iter == MAX_ITER−1 → OUT and set timeout.
  - Otherwise → UPD and increment iter.
- UPD → DIV.
- OUT → IDLE.

Rules:
- Moore outputs: all controls decode from the state register only.
- start is ignored while busy=1.
- iter clears on the IDLE→LOAD transition.
- Bypass: a flag records the bypass path (see Configuration). When set, OUT drives ADDR_RDA = R_N. The flag clears on IDLE→LOAD.

## Timing
- Reset values: state IDLE, iter 0, timeout 0, bypass flag 0. All outputs are 0 in IDLE.
- rst has priority over start and every transition. Reset mid-computation returns to IDLE at the next edge with all controls 0. No partial OUT is produced.
- The edge that samples start=1 is edge 0. LOAD occupies cycle 1.
- Convergence detected in iteration k (k ≥ 1): CMP is in cycle 7k+1 and OUT/done in cycle 7k+2. For k=1, done is in cycle 9.
- Timeout: done in cycle 7·MAX_ITER+2, with timeout=1 in that same cycle.
- busy falls in the cycle after OUT. A start in that IDLE cycle is accepted, so back-to-back computations have 1 idle cycle.

## Configuration
- SQRT_ZERO_BYPASS_EN defined:
  - In INIT, zero_flag=1 goes to OUT (not DIV), sets the bypass flag, and outputs n (0) directly. This avoids the n/x division by zero.
  - done arrives in cycle 3.
- Undefined: zero_flag is ignored (the port remains but is unused). INIT always goes to DIV.

## Test plan
- Reset: hold rst 2 cycles, then pulse start with rst=1 → state_o=0, busy=0, all controls 0.
- n=16, neg_flag=1 in the first CMP → done in cycle 9, OE=1 with ADDR_RDA=3, timeout=0, then IDLE.
- neg_flag=1 only in the 3rd CMP → UPD visited twice, done in cycle 23.
- neg_flag held 0, MAX_ITER=8 → done in cycle 58 with timeout=1. timeout stays 1 until the next start, then clears.
- n=0 with zero_flag=1 in INIT:
  - With the macro: done in cycle 3, ADDR_RDA=R_N.
  - Without the macro: the normal DIV path is taken.
- Robustness:
  - start pulsed during ADD → ignored.
  - rst asserted in HALF → IDLE at the next edge, with no done pulse.
